pwm_gpio_bank: RTL and testbench

//  Parametrised N-channel GPIO bank with a built-in PWM generator. Each pin is hi-Z input, static

---
 rtl/pwm_gpio_pkg.sv | 26 ++
 rtl/pwm_gpio_bank_if.sv | 25 ++
 rtl/pwm_gpio_bank_gpio_sync.sv | 26 ++
 rtl/pwm_gpio_bank.sv | 106 ++++++++++
 tb/tb_pwm_gpio_bank.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_gpio_pkg.sv
// Shared mode encodings and duty-field helper for the PWM GPIO bank.
package pwm_gpio_pkg;

  // Per-pin mode encodings, two bits per channel.
  localparam logic [1:0] MODE_HIZ     = 2'b00;
  localparam logic [1:0] MODE_OUT     = 2'b01;
  localparam logic [1:0] MODE_PWM     = 2'b10;
  localparam logic [1:0] MODE_PWM_INV = 2'b11;

  // Upper bounds for the helper below. Callers zero-extend to these widths
  // and truncate the result back to their own counter width.
  localparam int DUTY_BUS_MAX_W = 1024;
  localparam int CNT_MAX_W      = 32;

  // Extracts duty field idx (each w bits wide) from a flattened duty bus.
  function automatic logic [CNT_MAX_W-1:0] duty_field(
    input logic [DUTY_BUS_MAX_W-1:0] duty_bus,
    input int unsigned               idx,
    input int unsigned               w
  );
    logic [CNT_MAX_W-1:0] mask;
    mask = {CNT_MAX_W{1'b1}} >> (CNT_MAX_W - w);
    return CNT_MAX_W'(duty_bus >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/pwm_gpio_bank_if.sv
// Control/status bundle between the register block (master) and the GPIO bank (slave).
interface pwm_gpio_bank_if #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 8
);
  logic                    enable;
  logic [2*N_CH-1:0]       mode;
  logic [N_CH-1:0]         out_val;
  logic [CNT_W-1:0]        period;
  logic [N_CH*CNT_W-1:0]   duty;
  logic                    load_strobe;
  logic [N_CH-1:0]         pin_in;
  logic                    period_tick;
  logic                    load_pending;

  modport master (
    output enable, mode, out_val, period, duty, load_strobe,
    input  pin_in, period_tick, load_pending
  );

  modport slave (
    input  enable, mode, out_val, period, duty, load_strobe,
    output pin_in, period_tick, load_pending
  );
endinterface

// File: rtl/pwm_gpio_bank_gpio_sync.sv
// Multi-flop synchroniser for asynchronous pad read-back.
module gpio_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the pad value through the flop chain; all stages clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) chain[k] <= '0;
    end else begin
      chain[0] <= din;
      for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
    end
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/pwm_gpio_bank.sv
// N-channel GPIO bank with a shared PWM period counter, per-channel duty,
// double-buffered period/duty updates and registered pad drive.
module pwm_gpio_bank
  import pwm_gpio_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  pwm_gpio_bank_if.slave    bus,
  inout  wire  [N_CH-1:0]   io
);

  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        active_period;
  logic [CNT_W-1:0]        pending_period;
  logic [N_CH*CNT_W-1:0]   active_duty;
  logic [N_CH*CNT_W-1:0]   pending_duty;
  logic                    load_pending;
  logic                    at_term;
  logic                    apply_cyc;
  logic [N_CH-1:0]         pwm;
  logic [N_CH-1:0]         oe;
  logic [N_CH-1:0]         dout;
  logic [DUTY_BUS_MAX_W-1:0] duty_pad;

  assign at_term = (cnt == active_period);
  // The tick is combinational off the counter; the rst term keeps it quiet
  // while the bank is held in reset even if enable is already high.
  assign bus.period_tick  = bus.enable & ~rst & at_term;
  // Updates land either on the wrap cycle or while the counter is parked,
  // so the new values always start from a clean period.
  assign apply_cyc        = bus.period_tick | ~bus.enable;
  assign bus.load_pending = load_pending;

  // Period counter: free-runs 0..active_period while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (!bus.enable)  cnt <= '0;
    else if (at_term)      cnt <= '0;
    else                   cnt <= cnt + CNT_W'(1);
  end

  // Double buffer: a strobe on an apply cycle bypasses the pending stage,
  // otherwise it parks in pending (last strobe wins) until the next apply cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_period  <= '0;
      active_duty    <= '0;
      pending_period <= '0;
      pending_duty   <= '0;
      load_pending   <= 1'b0;
    end else if (apply_cyc) begin
      if (bus.load_strobe) begin
        active_period <= bus.period;
        active_duty   <= bus.duty;
        load_pending  <= 1'b0;
      end else if (load_pending) begin
        active_period <= pending_period;
        active_duty   <= pending_duty;
        load_pending  <= 1'b0;
      end
    end else if (bus.load_strobe) begin
      pending_period <= bus.period;
      pending_duty   <= bus.duty;
      load_pending   <= 1'b1;
    end
  end

  assign duty_pad = DUTY_BUS_MAX_W'(active_duty);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] duty_i;
    assign duty_i = CNT_W'(duty_field(duty_pad, i, CNT_W));
    // Duty above the period naturally yields 100% since cnt never reaches it.
    assign pwm[i] = bus.enable & (cnt < duty_i);
    assign io[i]  = oe[i] ? dout[i] : 1'bz;
  end

  // Registered pad drive so mode or level changes only ever switch on a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe   <= '0;
      dout <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        oe[i]   <= (bus.mode[2*i +: 2] != MODE_HIZ);
        dout[i] <= bus.mode[2*i+1] ? (pwm[i] ^ (bus.mode[2*i +: 2] == MODE_PWM_INV))
                                   : bus.out_val[i];
      end
    end
  end

  gpio_sync #(
    .WIDTH  (N_CH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (io),
    .dout (bus.pin_in)
  );

endmodule

// File: tb/tb_pwm_gpio_bank.sv
// Directed bench for pwm_gpio_bank: table of steady-state PWM patterns plus
// hand sequences for double-buffering, pad drive/read-back and mid-period reset.
module tb_pwm_gpio_bank;

  localparam int N_CH  = 8;
  localparam int CNT_W = 8;
  localparam int WIN   = 20;

  logic clk = 1'b0;
  logic rst;
  logic [N_CH-1:0] tb_oe;
  logic [N_CH-1:0] tb_val;
  wire  [N_CH-1:0] io;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_gpio_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  pwm_gpio_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .io  (io)
  );

  for (genvar g = 0; g < N_CH; g++) begin : g_pad
    assign io[g] = tb_oe[g] ? tb_val[g] : 1'bz;
  end

  typedef struct {
    logic [7:0] period;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] mode;
    logic [1:0] outv;
    int         hi0;
    int         hi1;
    int         ticks;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_direct(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [3:0] m, input logic [1:0] o);
    bus.enable      = 1'b0;
    bus.period      = p;
    bus.duty        = {48'b0, d1, d0};
    bus.mode        = {12'b0, m};
    bus.out_val     = {6'b0, o};
    bus.load_strobe = 1'b1;
    step();
    bus.load_strobe = 1'b0;
    bus.enable      = 1'b1;
  endtask

  initial begin
    int h0, h1, tk;

    vecs[0] = '{8'd9,   8'd3,   8'd0,  4'b1010, 2'b00,  6,  0,  2};
    vecs[1] = '{8'd9,   8'd3,   8'd12, 4'b1011, 2'b00, 14, 20,  2};
    vecs[2] = '{8'd9,   8'd7,   8'd10, 4'b1010, 2'b00, 14, 20,  2};
    vecs[3] = '{8'd0,   8'd1,   8'd0,  4'b1110, 2'b00, 20, 20, 20};
    vecs[4] = '{8'd4,   8'd2,   8'd4,  4'b1110, 2'b00,  8,  4,  4};
    vecs[5] = '{8'd255, 8'd255, 8'd0,  4'b1110, 2'b00, 20, 20,  0};
    vecs[6] = '{8'd9,   8'd5,   8'd5,  4'b0101, 2'b01, 20,  0,  2};

    rst             = 1'b1;
    tb_oe           = '0;
    tb_val          = '0;
    bus.enable      = 1'b0;
    bus.mode        = '0;
    bus.out_val     = '0;
    bus.period      = '0;
    bus.duty        = '0;
    bus.load_strobe = 1'b0;

    // Reset held with random controls: pads released, status quiet.
    for (int r = 0; r < 4; r++) begin
      bus.mode    = 16'($urandom);
      bus.out_val = 8'($urandom);
      bus.enable  = 1'($urandom_range(0, 1));
      tb_oe       = 8'hFF;
      tb_val      = (r % 2 == 0) ? 8'h5A : 8'hA5;
      step();
      chk("rst_oe",      32'(dut.oe), 32'h0);
      chk("rst_io",      32'(io), 32'(tb_val));
      chk("rst_pin_in",  32'(bus.pin_in), 32'h0);
      chk("rst_tick",    32'(bus.period_tick), 32'h0);
      chk("rst_pending", 32'(bus.load_pending), 32'h0);
    end
    tb_oe      = '0;
    bus.enable = 1'b0;
    bus.mode   = '0;
    step();
    rst = 1'b0;
    step();

    // Steady-state PWM patterns over two reference periods.
    for (int v = 0; v < 7; v++) begin
      load_direct(vecs[v].period, vecs[v].d0, vecs[v].d1, vecs[v].mode, vecs[v].outv);
      chk($sformatf("vec%0d_pending", v), 32'(bus.load_pending), 32'h0);
      h0 = 0; h1 = 0; tk = 0;
      for (int j = 1; j <= WIN; j++) begin
        step();
        h0 += int'(io[0]);
        h1 += int'(io[1]);
        tk += int'(bus.period_tick);
      end
      chk($sformatf("vec%0d_hi0", v),   32'(h0), 32'(vecs[v].hi0));
      chk($sformatf("vec%0d_hi1", v),   32'(h1), 32'(vecs[v].hi1));
      chk($sformatf("vec%0d_ticks", v), 32'(tk), 32'(vecs[v].ticks));
    end

    // Buffered duty change mid-period, then a strobe coinciding with the wrap.
    load_direct(8'd9, 8'd3, 8'd0, 4'b0010, 2'b00);
    h0 = 0; h1 = 0; tk = 0;
    for (int j = 1; j <= 30; j++) begin
      step();
      if (j <= 10)      h0 += int'(io[0]);
      else if (j <= 20) h1 += int'(io[0]);
      else              tk += int'(io[0]);
      if (j == 4) begin
        bus.duty        = {56'b0, 8'd7};
        bus.load_strobe = 1'b1;
      end
      if (j == 5) begin
        chk("buf_pending_set", 32'(bus.load_pending), 32'h1);
        bus.load_strobe = 1'b0;
      end
      if (j == 9) begin
        chk("buf_tick_term", 32'(bus.period_tick), 32'h1);
        chk("buf_pending_hold", 32'(bus.load_pending), 32'h1);
      end
      if (j == 10) chk("buf_pending_clr", 32'(bus.load_pending), 32'h0);
      if (j == 19) begin
        chk("byp_tick_term", 32'(bus.period_tick), 32'h1);
        bus.duty        = {56'b0, 8'd2};
        bus.load_strobe = 1'b1;
      end
      if (j == 20) begin
        chk("byp_no_pending", 32'(bus.load_pending), 32'h0);
        bus.load_strobe = 1'b0;
      end
    end
    chk("buf_old_period_hi", 32'(h0), 32'd3);
    chk("buf_new_period_hi", 32'(h1), 32'd7);
    chk("byp_period_hi",     32'(tk), 32'd2);

    // Static drive latency and synchronised read-back.
    bus.enable  = 1'b0;
    bus.mode    = {10'b0, 2'b00, 2'b00, 2'b01};
    bus.out_val = '0;
    step();
    step();
    chk("out_low", 32'(io[0]), 32'h0);
    bus.out_val = 8'h01;
    chk("out_no_comb_path", 32'(io[0]), 32'h0);
    step();
    chk("out_high_1cyc", 32'(io[0]), 32'h1);
    step();
    chk("own_readback_early", 32'(bus.pin_in[0]), 32'h0);
    step();
    chk("own_readback", 32'(bus.pin_in[0]), 32'h1);
    tb_oe[2]  = 1'b1;
    tb_val[2] = 1'b1;
    step();
    chk("ext_in_stage1", 32'(bus.pin_in[2]), 32'h0);
    step();
    chk("ext_in_stage2", 32'(bus.pin_in[2]), 32'h1);
    bus.out_val = 8'h00;
    step();
    chk("out_low_again", 32'(io[0]), 32'h0);
    tb_oe = '0;

    // Reset mid-period with an update pending.
    load_direct(8'd9, 8'd3, 8'd0, 4'b0010, 2'b00);
    for (int j = 0; j < 4; j++) step();
    bus.duty        = {56'b0, 8'd7};
    bus.load_strobe = 1'b1;
    step();
    bus.load_strobe = 1'b0;
    chk("mid_rst_pending_before", 32'(bus.load_pending), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_oe",      32'(dut.oe), 32'h0);
    chk("mid_rst_pending", 32'(bus.load_pending), 32'h0);
    chk("mid_rst_tick",    32'(bus.period_tick), 32'h0);
    chk("mid_rst_pin_in",  32'(bus.pin_in), 32'h0);
    step();
    rst        = 1'b0;
    bus.enable = 1'b0;
    step();
    bus.enable = 1'b1;
    h0 = 0; tk = 0;
    for (int j = 0; j < 10; j++) begin
      step();
      h0 += int'(io[0]);
      tk += int'(bus.period_tick);
    end
    chk("post_rst_hi0",   32'(h0), 32'd0);
    chk("post_rst_ticks", 32'(tk), 32'd10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
